// File: rtl/pipe_credit_fifo_pkg.sv
// pipe_credit_fifo_pkg: width helpers and parameter checks for pipe_credit_fifo
package pipe_credit_fifo_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // credit/count width: must hold the value DEPTH itself
   function automatic int cw_of(input int depth);
      return clog2(depth + 1);
   endfunction

   // pointer width: at least one bit even for a single-entry FIFO
   function automatic int pw_of(input int depth);
      return depth > 1 ? clog2(depth) : 1;
   endfunction

   function automatic bit depth_ok(input int depth);
      return depth >= 1 && depth <= 64;
   endfunction

endpackage

// File: rtl/pipe_credit_fifo_mem.sv
// pipe_credit_fifo_mem: circular result buffer with wrap-at-DEPTH pointers and occupancy count
module pipe_credit_fifo_mem
   import pipe_credit_fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = pw_of(DEPTH);
   localparam int CW = cw_of(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   assign full    = count_q == CW'(DEPTH);
   assign empty   = count_q == '0;
   assign rd_data = mem_q[rd_q];

   // next pointers and count; a write into a full buffer without a pop never grows count
   always_comb begin
      wr_d    = wr_en ? nxt(wr_q) : wr_q;
      rd_d    = rd_en ? nxt(rd_q) : rd_q;
      count_d = (wr_en && !rd_en && !full) ? count_q + CW'(1) :
                (rd_en && !wr_en)          ? count_q - CW'(1) : count_q;
   end

   // pointer and count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= wr_data;
   end

endmodule

// File: rtl/pipe_credit_fifo.sv
// pipe_credit_fifo: credit-gated issue into a fixed-latency pipeline plus result FIFO; PIPE_CREDIT_FIFO_OVF_CHECK_EN enables overflow drop/flag and checks
module pipe_credit_fifo
   import pipe_credit_fifo_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int LAT   = 3,
   parameter  int DEPTH = 5,
   localparam int CW    = cw_of(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             issue_fire,
   input  logic             pipe_valid,
   input  logic [WIDTH-1:0] pipe_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    credits,
   output logic             ovf
);

   localparam bit DEPTH_OK = depth_ok(DEPTH);

   if (!DEPTH_OK) begin : g_bad_depth
      $error("pipe_credit_fifo: DEPTH must be in 1..64");
   end

   logic [CW-1:0] credits_q, credits_d;
   logic          pop, ret, wr_en, full, empty;

   assign in_ready   = credits_q != '0;
   assign issue_fire = in_valid & in_ready;
   assign out_valid  = ~empty;
   assign pop        = out_valid & out_ready;
   assign credits    = credits_q;
   assign ret        = pop & (issue_fire | (credits_q != CW'(DEPTH)));

   // one credit per issue, one back per pop, never above DEPTH
   always_comb begin
      credits_d = credits_q - CW'(issue_fire) + CW'(ret);
   end

   // credit counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) credits_q <= CW'(DEPTH);
      else      credits_q <= credits_d;
   end

`ifdef PIPE_CREDIT_FIFO_OVF_CHECK_EN
   logic           ovf_q, drop;
   logic [LAT-1:0] iss_q;

   assign drop  = pipe_valid & full & ~pop;
   assign wr_en = pipe_valid & ~drop;
   assign ovf   = ovf_q;

   // sticky overflow flag and a LAT-deep record of issues to validate returning results
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         iss_q <= '0;
      end else begin
         ovf_q <= ovf_q | drop;
         iss_q <= (iss_q << 1) | LAT'(issue_fire);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !drop)
      else $error("pipe_credit_fifo: result written into full FIFO");
   a_issued: assert property (@(posedge clk) disable iff (!rst) pipe_valid |-> iss_q[LAT-1])
      else $error("pipe_credit_fifo: pipe_valid without matching issue");
`else
   logic unused_full;

   assign wr_en       = pipe_valid;
   assign ovf         = 1'b0;
   assign unused_full = full;
`endif

   pipe_credit_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (pipe_data),
      .rd_en   (pop),
      .rd_data (out_data),
      .full    (full),
      .empty   (empty)
   );

endmodule

// File: doc/pipe_credit_fifo.md
# pipe_credit_fifo

Consumer-side endpoint for fixed-latency, non-stallable datapath pipelines in the softmax engine, such as the 3-stage delay register chain. It gates issue into the pipeline with a credit counter and captures every result LAT cycles later into a small FIFO. It then delivers results to a downstream consumer over a valid/ready handshake. This lets a pipeline with no stall input run safely against a back-pressuring consumer.

## Interface
Parameters:
- WIDTH, 16, result data width in bits
- LAT, 3, fixed cycles from issue_fire to the matching pipe_valid
- DEPTH, 5, FIFO entries; legal range 1 to 64; DEPTH ≥ LAT+2 is required for one result per cycle

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  producer requests an issue into the pipeline
- in_ready  out  1  issue permitted; equals (credits != 0)
- issue_fire  out  1  in_valid & in_ready; drives the pipeline's valid input
- pipe_valid  in  1  pipeline result valid; arrives exactly LAT cycles after issue_fire
- pipe_data  in  WIDTH  pipeline result
- out_valid  out  1  FIFO holds at least one entry
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  FIFO head entry
- credits  out  CW  free credits; CW = clog2(DEPTH+1)
- ovf  out  1  sticky overflow flag (see Configuration)

## Operation
- Credits start at DEPTH. Each credit covers one slot, either in flight in the pipeline or occupied in the FIFO.
- issue_fire consumes one credit. A pop (out_valid & out_ready) returns one credit. Both in the same cycle leave credits unchanged.
- credits never exceeds DEPTH and never underflows. in_ready is 0 whenever credits is 0.
- pipe_valid=1 writes pipe_data at the write pointer and increments count.
- A pop advances the read pointer and decrements count.
- A simultaneous write and pop leaves count unchanged.
- Both pointers wrap from DEPTH-1 to 0. DEPTH is not required to be a power of two.
- out_data is the storage entry at the read pointer. out_valid = (count != 0).
- There is no write-to-read bypass. An empty FIFO presents out_valid=0 regardless of pipe_valid.
- Write while full (count==DEPTH): accepted if a pop occurs in the same cycle; otherwise it is an overflow. This cannot happen under correct credit use.
- out_data is don't-care while out_valid=0. out_data is stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: credits=DEPTH, count=0, both pointers=0, out_valid=0, in_ready=1, issue_fire=0, ovf=0. Storage is not reset.
- in_ready and issue_fire are combinational from the credits register and in_valid. No other output has a combinational path from an input.
- Latency from pipe_valid (cycle t) to out_valid is 1 cycle (t+1).
- Round trip: issue at t, pipe_valid at t+LAT, out_valid at t+LAT+1, pop at t+LAT+1, credit usable at t+LAT+2.
- Reset asserted mid-operation discards all in-flight and stored results. The pipeline owner must reset the pipeline with the same rst.

## Configuration
- Macro: PIPE_CREDIT_FIFO_OVF_CHECK_EN.
- Defined:
  - An overflow write is dropped; storage, count and pointers are unchanged.
  - ovf sets and stays set until reset.
  - A simulation-only assertion fires on overflow and on pipe_valid with no outstanding issue.
- Undefined:
  - ovf is tied to 0 and no check logic is built.
  - An overflow write overwrites the entry at the write pointer; the result is undefined.

## Structure
- Package pipe_credit_fifo_pkg holds:
  - a clog2 function
  - the CW/pointer-width derivation
  - a check parameter that evaluates DEPTH ≥ 1
- Sub-module pipe_credit_fifo_mem holds the storage array, the write and read pointers, and count. It exposes wr_en, rd_en, full, empty and head data.
- The top level holds the credit counter, the issue gate and the overflow logic.

## Test plan
- Reset then idle, with defaults → credits=5, in_ready=1, out_valid=0, ovf=0.
- in_valid held 1, out_ready held 1, LAT=3, DEPTH=5, model pipeline as a 3-cycle delay → after a 4-cycle fill, out_valid=1 every cycle; credits settles and stays at 0 or above; data order preserved.
- out_ready=0, in_valid=1 → exactly 5 issues, then in_ready=0 with credits=0. After results land, count=5. Raising out_ready pops 5 entries in order and credits returns to 5.
- Full FIFO, a pop and an injected pipe_valid in the same cycle → count stays 5, no ovf, new entry appears last.
- With the macro defined: inject pipe_valid into a full FIFO with out_ready=0 → ovf=1 (sticky), data dropped, head unchanged.
- Assert rst mid-stream with 3 results in flight → next cycle credits=5, out_valid=0. Stale pipe_valid after reset is not observed when the pipeline is also reset.
